sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
- Shares the board's single asynchronous 48-bit SRAM between two requesters.
  - Port 0: display/scan-out reader, read-only, high priority.
  - Port 1: host read/write port (UART loader, debug).
- Generates all SRAM strobe timing and an output-enable for the data bus.
- The top level owns the tristate: dq = sram_dq_oe ? sram_dout : 'z.
- Sits in the clk_sys domain between the requesters and the SRAM pins.

Parameters:
- ADDR_W, 20, SRAM address width.
- DATA_W, 48, SRAM data width.
- WAIT_CYCLES, 2, cycles the read strobe (oen) or write pulse (wen) is held low; must be ≥1.
- STARVE_LIMIT, 4, consecutive port-0 grants allowed while port 1 waits; must be ≥1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  synchronous reset, active-high.
- p0_req  in  1  port-0 read request; held until p0_ack.
- p0_addr  in  ADDR_W  port-0 address.
- p0_ack  out  1  one-cycle pulse; p0_rdata valid in the same cycle.
- p0_rdata  out  DATA_W  port-0 read data; holds until the next port-0 read completes.
- p1_req  in  1  port-1 request; held until p1_ack.
- p1_we  in  1  1 = write, 0 = read.
- p1_addr  in  ADDR_W  port-1 address.
- p1_wdata  in  DATA_W  port-1 write data.
- p1_ack  out  1  one-cycle completion pulse.
- p1_rdata  out  DATA_W  port-1 read data; valid with p1_ack, held afterwards.
- sram_addr  out  ADDR_W  SRAM address.
- sram_dout  out  DATA_W  write data to the pad.
- sram_dq_oe  out  1  drive the data bus.
- sram_din  in  DATA_W  data from the pad.
- sram_ce  out  1  chip enable, active-low.
- sram_oen  out  1  output enable, active-low.
- sram_wen  out  1  write enable, active-low.
- busy  out  1  1 when the FSM is not in IDLE.

Behaviour:
- Reset values: sram_ce, sram_oen and sram_wen = 1; sram_dq_oe = 0; sram_addr and sram_dout = 0; p0_ack and p1_ack = 0; p0_rdata and p1_rdata = 0; starvation counter = 0; FSM in IDLE; busy = 0.
- All outputs are registered.
- FSM states: IDLE, RD_ACC, WR_SETUP, WR_PULSE, DONE.
- IDLE, arbitration when any request is pending:
  - Port 1 wins only if p1_req is high and either p0_req is low or the counter equals STARVE_LIMIT.
  - Otherwise port 0 wins.
  - Winner's address is latched to sram_addr; for a port-1 write, p1_wdata is latched to sram_dout.
  - Next state: a read goes to RD_ACC; a write goes to WR_SETUP.
- Starvation counter (updated at each grant):
  - Increments on a port-0 grant while p1_req is high; saturates at STARVE_LIMIT.
  - Clears on a port-1 grant, or on any grant with p1_req low.
- RD_ACC:
  - ce = 0, oen = 0, wen = 1, dq_oe = 0.
  - Lasts WAIT_CYCLES cycles.
  - sram_din is captured on the last cycle into the winner's rdata register.
  - Then goes to DONE.
- WR_SETUP: 1 cycle; ce = 0, dq_oe = 1, wen = 1.
- WR_PULSE: WAIT_CYCLES cycles; ce = 0, wen = 0, dq_oe = 1.
- DONE: 1 cycle.
  - ce, oen and wen = 1.
  - dq_oe stays 1 for a write (data hold) and is 0 for a read.
  - The winner's ack = 1.
  - Next state is IDLE.
- Latency, counted from the IDLE cycle in which the request is sampled (cycle 0):
  - Read: ack in cycle 1 + WAIT_CYCLES.
  - Write: ack in cycle 2 + WAIT_CYCLES.
  - Back-to-back accesses insert one IDLE cycle.
- Handshake:
  - req and its fields must stay stable until ack.
  - A requester that registers ack deasserts req at that same edge, so the following IDLE does not re-grant it.
  - A req still high in IDLE is treated as a new request.
- Simultaneous requests in IDLE: port 0 wins unless the counter has reached STARVE_LIMIT.
- sram_addr holds its value while IDLE; only the strobes indicate a valid cycle.
- Reset mid-operation: at the reset edge the FSM returns to IDLE and all strobes and dq_oe are deasserted; no ack is issued for the aborted access; rdata registers clear.
- Requests arriving while busy wait; they are never dropped.

Test Plan:
- Port-0 read of 0x00010 with sram_din = 48'h123456789ABC during RD_ACC -> oen = 0 in cycles 1–2, wen = 1 throughout, p0_ack in cycle 3, p0_rdata = 48'h123456789ABC.
- Port-1 write of 48'hA5A5A5A5A5A5 to 0xFFFFF -> sram_addr = 0xFFFFF, dq_oe = 1 in cycles 1–4, wen = 0 only in cycles 2–3, p1_ack in cycle 4, p0_ack stays 0.
- p0_req and p1_req (read 0x00020) raised in the same cycle -> port 0 is acked first, then after one IDLE cycle port 1 is granted, and p1_ack occurs 3 cycles later.
- p0_req held continuously with p1_req pending -> four port-0 acks, then port 1 granted; after p1_ack the counter is 0 and port 0 resumes.
- rst pulsed during WR_PULSE -> next cycle ce, wen = 1, dq_oe = 0, busy = 0; no p1_ack ever occurs; a re-issued request completes normally.
- WAIT_CYCLES = 1 -> read ack in cycle 2, write wen low for exactly 1 cycle, write ack in cycle 3.

Source files
------------

// File: rtl/sram_arbiter.sv
// Two-port arbiter for the shared asynchronous SRAM: port 0 is the high-priority
// scan-out reader, port 1 the host read/write port. All outputs are registered.
module sram_arbiter #(
   parameter int ADDR_W       = 20,
   parameter int DATA_W       = 48,
   parameter int WAIT_CYCLES  = 2,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_req,
   input  logic [ADDR_W-1:0] p0_addr,
   output logic              p0_ack,
   output logic [DATA_W-1:0] p0_rdata,
   input  logic              p1_req,
   input  logic              p1_we,
   input  logic [ADDR_W-1:0] p1_addr,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p1_ack,
   output logic [DATA_W-1:0] p1_rdata,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_dout,
   output logic              sram_dq_oe,
   input  logic [DATA_W-1:0] sram_din,
   output logic              sram_ce,
   output logic              sram_oen,
   output logic              sram_wen,
   output logic              busy
);

   // state    | meaning
   // IDLE     | no access; arbitrate pending requests
   // RD_ACC   | ce/oen low for WAIT_CYCLES, capture din on the last cycle
   // WR_SETUP | ce low, bus driven, wen still high (address/data setup)
   // WR_PULSE | wen low for WAIT_CYCLES
   // DONE     | strobes released, winner acked; write data held on the bus

   localparam int WW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
   localparam int SW = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [2:0] {IDLE, RD_ACC, WR_SETUP, WR_PULSE, DONE} state_t;

   state_t          state;
   logic [WW-1:0]   wait_cnt;
   logic [SW-1:0]   starve;
   logic            owner;
   logic            p1_wins;

   assign p1_wins = p1_req && (!p0_req || starve == SW'(STARVE_LIMIT));

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         starve     <= '0;
         owner      <= 1'b0;
         p0_ack     <= 1'b0;
         p1_ack     <= 1'b0;
         p0_rdata   <= '0;
         p1_rdata   <= '0;
         sram_addr  <= '0;
         sram_dout  <= '0;
         sram_dq_oe <= 1'b0;
         sram_ce    <= 1'b1;
         sram_oen   <= 1'b1;
         sram_wen   <= 1'b1;
         busy       <= 1'b0;
      end else begin
         p0_ack <= 1'b0;
         p1_ack <= 1'b0;
         case (state)
            IDLE: begin
               if (p0_req || p1_req) begin
                  busy     <= 1'b1;
                  sram_ce  <= 1'b0;
                  wait_cnt <= WW'(WAIT_CYCLES - 1);
                  if (p1_wins) begin
                     owner     <= 1'b1;
                     sram_addr <= p1_addr;
                     starve    <= '0;
                     if (p1_we) begin
                        sram_dout  <= p1_wdata;
                        sram_dq_oe <= 1'b1;
                        state      <= WR_SETUP;
                     end else begin
                        sram_oen <= 1'b0;
                        state    <= RD_ACC;
                     end
                  end else begin
                     owner     <= 1'b0;
                     sram_addr <= p0_addr;
                     sram_oen  <= 1'b0;
                     state     <= RD_ACC;
                     // Count only grants that made port 1 wait; saturate at the limit.
                     if (!p1_req)
                        starve <= '0;
                     else if (starve != SW'(STARVE_LIMIT))
                        starve <= starve + SW'(1);
                  end
               end
            end
            RD_ACC: begin
               if (wait_cnt == '0) begin
                  sram_oen <= 1'b1;
                  sram_ce  <= 1'b1;
                  if (owner) begin
                     p1_rdata <= sram_din;
                     p1_ack   <= 1'b1;
                  end else begin
                     p0_rdata <= sram_din;
                     p0_ack   <= 1'b1;
                  end
                  state <= DONE;
               end else begin
                  wait_cnt <= wait_cnt - WW'(1);
               end
            end
            WR_SETUP: begin
               sram_wen <= 1'b0;
               state    <= WR_PULSE;
            end
            WR_PULSE: begin
               if (wait_cnt == '0) begin
                  sram_wen <= 1'b1;
                  sram_ce  <= 1'b1;
                  p1_ack   <= 1'b1;
                  state    <= DONE;
               end else begin
                  wait_cnt <= wait_cnt - WW'(1);
               end
            end
            DONE: begin
               sram_dq_oe <= 1'b0;
               busy       <= 1'b0;
               state      <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
